// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the LEGv8 immediate generator.
// Each format is matched by comparing a fixed-width prefix of the
// instruction word against the constants below.
package imm_pkg;

    // Instruction format reported alongside each immediate
    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_D     = 3'd1,
        FMT_CB    = 3'd2,
        FMT_B     = 3'd3,
        FMT_I     = 3'd4,
        FMT_SHIFT = 3'd5,
        FMT_MOV   = 3'd6
    } fmt_e;

    // D-format loads/stores: opcode in instr[31:21]
    localparam logic [10:0] OPC_LDUR  = 11'h7C2;
    localparam logic [10:0] OPC_STUR  = 11'h7C0;

    // Compare-and-branch: opcode in instr[31:24]
    localparam logic [7:0]  OPC_CBZ   = 8'hB4;
    localparam logic [7:0]  OPC_CBNZ  = 8'hB5;

    // Unconditional branch: opcode in instr[31:26]
    localparam logic [5:0]  OPC_B     = 6'b000101;

    // Arithmetic immediates: opcode in instr[31:22]
    localparam logic [9:0]  OPC_ADDI  = 10'h244;
    localparam logic [9:0]  OPC_SUBI  = 10'h344;

    // Shifts by immediate: opcode in instr[31:21]
    localparam logic [10:0] OPC_LSL   = 11'h69B;
    localparam logic [10:0] OPC_LSR   = 11'h69A;

    // Wide move: opcode in instr[31:23], hw field in instr[22:21]
    localparam logic [8:0]  OPC_MOVZ  = 9'h1A5;

    // Immediate field widths
    localparam int D_IMM_W   = 9;
    localparam int CB_IMM_W  = 19;
    localparam int B_IMM_W   = 26;
    localparam int I_IMM_W   = 12;
    localparam int SH_IMM_W  = 6;
    localparam int MOV_IMM_W = 16;

endpackage

// File: rtl/imm_decode.sv
// Combinational instruction classifier and immediate extractor.
// Produces the N-bit immediate, its format and an illegal flag for a
// single 32-bit instruction word. Branch offsets are optionally scaled
// from words to bytes after sign extension.
module imm_decode
    import imm_pkg::*;
#(
    parameter int N        = 64,
    parameter bit BR_SHIFT = 1'b1
) (
    input  logic [31:0]  instr,
    output logic [N-1:0] imm,
    output fmt_e         fmt,
    output logic         illegal
);

    logic                    is_d;
    logic                    is_cb;
    logic                    is_b;
    logic                    is_i;
    logic                    is_sh;
    logic                    is_mov;

    logic signed [D_IMM_W-1:0]  d_raw;
    logic signed [CB_IMM_W-1:0] cb_raw;
    logic signed [B_IMM_W-1:0]  b_raw;

    logic signed [N-1:0]     d_ext;
    logic signed [N-1:0]     cb_ext;
    logic signed [N-1:0]     b_ext;
    logic signed [N-1:0]     cb_imm;
    logic signed [N-1:0]     b_imm;

    logic [N-1:0]            i_imm;
    logic [N-1:0]            sh_imm;
    logic [N-1:0]            mov_base;
    logic [N-1:0]            mov_imm;
    logic [5:0]              mov_sh;

    // Rt/Rd field carries no immediate bits in any format
    logic                    unused_rt;
    assign unused_rt = ^instr[4:0];

    // Opcode prefix matches for every recognised format
    always_comb begin
        is_d   = (instr[31:21] == OPC_LDUR) || (instr[31:21] == OPC_STUR);
        is_cb  = (instr[31:24] == OPC_CBZ)  || (instr[31:24] == OPC_CBNZ);
        is_b   = (instr[31:26] == OPC_B);
        is_i   = (instr[31:22] == OPC_ADDI) || (instr[31:22] == OPC_SUBI);
        is_sh  = (instr[31:21] == OPC_LSL)  || (instr[31:21] == OPC_LSR);
        is_mov = (instr[31:23] == OPC_MOVZ);
    end

    // Sign-extend the signed fields, then scale branch offsets at width N
    always_comb begin
        d_raw  = instr[20:12];
        cb_raw = instr[23:5];
        b_raw  = instr[25:0];

        d_ext  = {{(N-D_IMM_W){d_raw[D_IMM_W-1]}}, d_raw};
        cb_ext = {{(N-CB_IMM_W){cb_raw[CB_IMM_W-1]}}, cb_raw};
        b_ext  = {{(N-B_IMM_W){b_raw[B_IMM_W-1]}}, b_raw};

        if (BR_SHIFT) begin
            cb_imm = cb_ext <<< 2;
            b_imm  = b_ext <<< 2;
        end else begin
            cb_imm = cb_ext;
            b_imm  = b_ext;
        end
    end

    // Zero-extend the unsigned fields; MOVZ places its 16 bits by hw*16,
    // with anything shifted past bit N-1 discarded
    always_comb begin
        i_imm    = {{(N-I_IMM_W){1'b0}}, instr[21:10]};
        sh_imm   = {{(N-SH_IMM_W){1'b0}}, instr[15:10]};
        mov_base = {{(N-MOV_IMM_W){1'b0}}, instr[20:5]};
        mov_sh   = {instr[22:21], 4'b0000};
        mov_imm  = mov_base << mov_sh;
    end

    // First matching format wins, in D, CB, B, I, SHIFT, MOV order
    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        if (is_d) begin
            imm = d_ext;
            fmt = FMT_D;
        end else if (is_cb) begin
            imm = cb_imm;
            fmt = FMT_CB;
        end else if (is_b) begin
            imm = b_imm;
            fmt = FMT_B;
        end else if (is_i) begin
            imm = i_imm;
            fmt = FMT_I;
        end else if (is_sh) begin
            imm = sh_imm;
            fmt = FMT_SHIFT;
        end else if (is_mov) begin
            imm = mov_imm;
            fmt = FMT_MOV;
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes each accepted instruction and
// queues {imm, fmt, illegal, tag} in a DEPTH-entry FIFO between fetch and
// decode. in_ready is a register so no combinational path exists from
// out_ready back to fetch; the cost is that a full FIFO cannot accept in
// the same cycle it is popped.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int N        = 64,
    parameter int DEPTH    = 2,
    parameter int TAG_W    = 64,
    parameter bit BR_SHIFT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_imm,
    output fmt_e             out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Decoder outputs for the instruction currently offered
    logic [N-1:0]     dec_imm;
    fmt_e             dec_fmt;
    logic             dec_illegal;

    // Control state
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_ready_q;

    // FIFO storage (data only, never reset)
    logic [N-1:0]     imm_mem_q [DEPTH];
    fmt_e             fmt_mem_q [DEPTH];
    logic             ill_mem_q [DEPTH];
    logic [TAG_W-1:0] tag_mem_q [DEPTH];

    logic             head_valid;
    logic             push;
    logic             pop;

    imm_decode #(
        .N        (N),
        .BR_SHIFT (BR_SHIFT)
    ) u_decode (
        .instr   (instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    // Handshake qualification; flush suppresses both transfers
    always_comb begin
        head_valid = (count_q != '0);
        push       = in_valid && in_ready_q && !flush;
        pop        = head_valid && out_ready && !flush;
    end

    // Next pointer and occupancy; flush empties the FIFO outright
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers; in_ready is precomputed from next occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= (count_d < DEPTH_C);
        end
    end

    // Capture the decoded entry at the write pointer on every push
    always_ff @(posedge clk) begin
        if (push) begin
            imm_mem_q[wr_ptr_q] <= dec_imm;
            fmt_mem_q[wr_ptr_q] <= dec_fmt;
            ill_mem_q[wr_ptr_q] <= dec_illegal;
            tag_mem_q[wr_ptr_q] <= in_tag;
        end
    end

    // Present the head entry, forcing data to zero while nothing is valid
    always_comb begin
        in_ready    = in_ready_q;
        out_valid   = head_valid;
        out_imm     = '0;
        out_fmt     = FMT_NONE;
        out_illegal = 1'b0;
        out_tag     = '0;
        if (head_valid) begin
            out_imm     = imm_mem_q[rd_ptr_q];
            out_fmt     = fmt_mem_q[rd_ptr_q];
            out_illegal = ill_mem_q[rd_ptr_q];
            out_tag     = tag_mem_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: two instances (branch scaling on and
// off) share all inputs; expected entries are queued at acceptance and
// popped by a negedge monitor when each DUT hands an entry over.
module tb_imm_gen_pipe;
    import imm_pkg::*;

    localparam int N     = 64;
    localparam int DEPTH = 2;
    localparam int TAG_W = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             out_ready;
    logic [31:0]      instr;
    logic [TAG_W-1:0] in_tag;

    logic             in_ready_a, out_valid_a, ill_a;
    logic [N-1:0]     imm_a;
    logic [TAG_W-1:0] tag_a;
    fmt_e             fmt_a;

    logic             in_ready_b, out_valid_b, ill_b;
    logic [N-1:0]     imm_b;
    logic [TAG_W-1:0] tag_b;
    fmt_e             fmt_b;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [63:0] imm;
        fmt_e        fmt;
        logic        ill;
        logic [63:0] tag;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.N(N), .DEPTH(DEPTH), .TAG_W(TAG_W), .BR_SHIFT(1'b1)) u_dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .instr(instr), .in_tag(in_tag),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_imm(imm_a),
        .out_fmt(fmt_a), .out_illegal(ill_a), .out_tag(tag_a)
    );

    imm_gen_pipe #(.N(N), .DEPTH(DEPTH), .TAG_W(TAG_W), .BR_SHIFT(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .instr(instr), .in_tag(in_tag),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_imm(imm_b),
        .out_fmt(fmt_b), .out_illegal(ill_b), .out_tag(tag_b)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference decode: plain integer arithmetic on the instruction fields
    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] tag, input bit brs);
        exp_t   e;
        longint v;
        e.tag = tag;
        e.ill = 1'b0;
        e.fmt = FMT_NONE;
        v     = 0;
        if (ins[31:21] == 11'h7C2 || ins[31:21] == 11'h7C0) begin
            v = longint'(ins[20:12]);
            if (v >= 256) v = v - 512;
            e.fmt = FMT_D;
        end else if (ins[31:24] == 8'hB4 || ins[31:24] == 8'hB5) begin
            v = longint'(ins[23:5]);
            if (v >= 262144) v = v - 524288;
            if (brs) v = v * 4;
            e.fmt = FMT_CB;
        end else if (ins[31:26] == 6'b000101) begin
            v = longint'(ins[25:0]);
            if (v >= 33554432) v = v - 67108864;
            if (brs) v = v * 4;
            e.fmt = FMT_B;
        end else if (ins[31:22] == 10'h244 || ins[31:22] == 10'h344) begin
            v = longint'(ins[21:10]);
            e.fmt = FMT_I;
        end else if (ins[31:21] == 11'h69B || ins[31:21] == 11'h69A) begin
            v = longint'(ins[15:10]);
            e.fmt = FMT_SHIFT;
        end else if (ins[31:23] == 9'h1A5) begin
            e.fmt = FMT_MOV;
        end else begin
            e.ill = 1'b1;
        end
        e.imm = v;
        if (e.fmt == FMT_MOV)
            e.imm = 64'(ins[20:5]) * (64'd1 << (16 * int'(ins[22:21])));
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic        alt;
        r   = $urandom;
        alt = r[31];
        case ($urandom_range(0, 6))
            0: return {(alt ? 11'h7C2 : 11'h7C0), r[20:0]};
            1: return {(alt ? 8'hB4 : 8'hB5), r[23:0]};
            2: return {6'b000101, r[25:0]};
            3: return {(alt ? 10'h244 : 10'h344), r[21:0]};
            4: return {(alt ? 11'h69B : 11'h69A), r[20:0]};
            5: return {9'h1A5, r[22:0]};
            default: return r;
        endcase
    endfunction

    task automatic cmp_entry(input string nm, input exp_t e, input logic [63:0] imm,
                             input fmt_e f, input logic ill, input logic [63:0] tag);
        chk({nm, "_imm"}, imm, e.imm);
        chk({nm, "_fmt"}, 64'(f), 64'(e.fmt));
        chk({nm, "_ill"}, 64'(ill), 64'(e.ill));
        chk({nm, "_tag"}, tag, e.tag);
    endtask

    // Accept-side: record the expected entry whenever a push occurs
    always @(posedge clk) begin
        if (!reset) begin
            if (flush) begin
                qa.delete();
                qb.delete();
            end else if (in_valid && in_ready_a) begin
                qa.push_back(model(instr, in_tag, 1'b1));
                qb.push_back(model(instr, in_tag, 1'b0));
            end
        end
    end

    // Output-side monitor: compare heads on handshake, zeros when idle
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid_a) begin
                if (qa.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL sb_a_unexpected: out_valid=1 tag=%h, expected no entry", tag_a);
                end else if (out_ready) begin
                    cmp_entry("sb_a", qa[0], imm_a, fmt_a, ill_a, tag_a);
                    void'(qa.pop_front());
                end
            end else begin
                chk("idle_a_data", {imm_a[62:0] | tag_a[62:0], imm_a[63] | tag_a[63]},
                    64'd0);
                chk("idle_a_fmt_ill", {60'd0, fmt_a, ill_a}, 64'd0);
            end
            if (out_valid_b) begin
                if (qb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL sb_b_unexpected: out_valid=1 tag=%h, expected no entry", tag_b);
                end else if (out_ready) begin
                    cmp_entry("sb_b", qb[0], imm_b, fmt_b, ill_b, tag_b);
                    void'(qb.pop_front());
                end
            end else begin
                chk("idle_b_imm", imm_b, 64'd0);
            end
        end
    end

    // Offer one instruction until accepted, bounded
    task automatic send(input logic [31:0] i, input logic [63:0] t);
        logic acc;
        int   n;
        in_valid = 1'b1;
        instr    = i;
        in_tag   = t;
        n        = 0;
        acc      = 1'b0;
        while (!acc && n < 50) begin
            acc = in_ready_a;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected acceptance", n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        instr     = '0;
        in_tag    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready_a), 64'd1);
        chk("rst_out_valid", 64'(out_valid_a), 64'd0);
        chk("rst_out_imm", imm_a, 64'd0);
        chk("rst_out_tag", tag_a, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // LDUR positive and negative offsets, one-cycle latency
        send(32'hF8410020, 64'h100);
        chk("ldur_valid", 64'(out_valid_a), 64'd1);
        chk("ldur_imm", imm_a, 64'h10);
        chk("ldur_fmt", 64'(fmt_a), 64'(FMT_D));
        send(32'hF85F8020, 64'h101);
        chk("ldur_neg_imm", imm_a, 64'hFFFF_FFFF_FFFF_FFF8);

        // CBZ with offset -1, scaled and unscaled
        send(32'hB4FFFFE0, 64'h102);
        chk("cbz_imm_shift", imm_a, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("cbz_imm_raw", imm_b, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("cbz_fmt", 64'(fmt_a), 64'(FMT_CB));

        // MOVZ #0x1234, LSL 16
        send(32'hD2A24681, 64'h103);
        chk("movz_imm", imm_a, 64'h1234_0000);
        chk("movz_fmt", 64'(fmt_a), 64'(FMT_MOV));

        // All-zero word is illegal
        send(32'h0, 64'h104);
        chk("zero_ill", 64'(ill_a), 64'd1);
        chk("zero_fmt", 64'(fmt_a), 64'(FMT_NONE));
        chk("zero_imm", imm_a, 64'd0);
        @(posedge clk); #1;

        // Backpressure: three offered, two accepted, in-order drain
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int j = 0; j < 3; j++) begin
            instr  = rand_instr();
            in_tag = 64'h400 + 64'(j);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("full_in_ready", 64'(in_ready_a), 64'd0);
        chk("full_out_valid", 64'(out_valid_a), 64'd1);
        chk("full_head_tag", tag_a, 64'h400);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("pop1_in_ready", 64'(in_ready_a), 64'd1);
        chk("pop1_head_tag", tag_a, 64'h401);
        @(posedge clk); #1;
        chk("drain_out_valid", 64'(out_valid_a), 64'd0);

        // Flush while full with a concurrent input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'hF8410020;
        in_tag    = 64'h500;
        @(posedge clk); #1;
        in_tag = 64'h501;
        @(posedge clk); #1;
        flush  = 1'b1;
        in_tag = 64'h502;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid_a), 64'd0);
        chk("flush_in_ready", 64'(in_ready_a), 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("flush_nostore", 64'(out_valid_a), 64'd0);
        send(32'hF8410020, 64'h503);
        chk("post_flush_tag", tag_a, 64'h503);
        @(posedge clk); #1;
        chk("post_flush_empty", 64'(out_valid_a), 64'd0);

        // Flush with room to accept: the concurrent input is dropped
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 64'h520;
        flush     = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_drop_input", 64'(out_valid_a), 64'd0);
        out_ready = 1'b1;

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'hD2A24681;
        in_tag    = 64'h600;
        @(posedge clk); #1;
        in_tag = 64'h601;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        qa.delete();
        qb.delete();
        #1;
        chk("arst_out_valid", 64'(out_valid_a), 64'd0);
        chk("arst_in_ready", 64'(in_ready_a), 64'd1);
        chk("arst_out_imm", imm_a, 64'd0);
        chk("arst_out_tag", tag_a, 64'd0);
        chk("arst_fmt_ill", {60'd0, fmt_a, ill_a}, 64'd0);
        @(posedge clk); #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("arst_stays_empty", 64'(out_valid_a), 64'd0);

        // Randomized traffic with random backpressure and rare flushes
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            instr     = rand_instr();
            in_tag    = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 59) == 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("final_out_valid", 64'(out_valid_a), 64'd0);
        chk("final_sb_a_empty", 64'(qa.size()), 64'd0);
        chk("final_sb_b_empty", 64'(qb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
